scarv_cop_mp_issue: RTL and testbench

- Issue/writeback-steering stage directly upstream of the multi-precision arithmetic unit (MALU).
- Accepts one decoded coprocessor instruction from the CPU interface (valid/ack), latches operands and decode fields, and holds the MALU valid until it reports done.
- Converts the MALU's per-cycle writeback words into addressed CPR writes (single register or even/odd pair).
- Returns a completion/error response to the CPU; a watchdog aborts hung operations.

---
 rtl/scarv_cop_mp_issue_pkg.sv | 40 ++++
 rtl/scarv_cop_mp_issue_if.sv | 32 +++
 rtl/scarv_cop_mp_wdog.sv | 29 ++
 rtl/scarv_cop_mp_issue.sv | 165 ++++++++++++++++
 tb/tb_scarv_cop_mp_issue.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scarv_cop_mp_issue_pkg.sv
// Shared definitions for the multi-precision issue stage: FSM encoding,
// MP subclass codes shared with the MALU, and the register-pair decode.
package scarv_cop_mp_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPRD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } issue_state_e;

  localparam logic [3:0] SC_EQU  = 4'd0;
  localparam logic [3:0] SC_LTU  = 4'd1;
  localparam logic [3:0] SC_GTU  = 4'd2;
  localparam logic [3:0] SC_ADD3 = 4'd3;
  localparam logic [3:0] SC_ADD2 = 4'd4;
  localparam logic [3:0] SC_SUB3 = 4'd5;
  localparam logic [3:0] SC_SUB2 = 4'd6;
  localparam logic [3:0] SC_SLLI = 4'd7;
  localparam logic [3:0] SC_SLL  = 4'd8;
  localparam logic [3:0] SC_SRLI = 4'd9;
  localparam logic [3:0] SC_SRL  = 4'd10;
  localparam logic [3:0] SC_ACC2 = 4'd11;
  localparam logic [3:0] SC_ACC1 = 4'd12;
  localparam logic [3:0] SC_MAC  = 4'd13;

  // Decode fields handed to the MALU unchanged for the whole operation.
  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  subclass;
    logic [31:0] imm;
    logic [31:0] gpr_rs1;
  } decode_t;

  // Comparisons produce a single word; every other MP op writes an even/odd pair.
  function automatic logic is_pair_op(input logic [3:0] subclass);
    return !(subclass inside {SC_EQU, SC_LTU, SC_GTU});
  endfunction

endpackage

// File: rtl/scarv_cop_mp_issue_if.sv
// CPU-side instruction offer and completion response of the MP issue stage.
interface scarv_cop_mp_issue_if #(
  parameter int unsigned CPR_AW = 4
) ();

  logic              insn_valid;
  logic              insn_ack;
  logic [2:0]        id_class;
  logic [3:0]        id_subclass;
  logic [31:0]       id_imm;
  logic [CPR_AW-1:0] id_crd;
  logic [CPR_AW-1:0] id_crs1;
  logic [CPR_AW-1:0] id_crs2;
  logic [CPR_AW-1:0] id_crs3;
  logic [31:0]       gpr_rs1_in;
  logic              rsp_valid;
  logic              rsp_error;
  logic              rsp_ack;

  modport master (
    output insn_valid, id_class, id_subclass, id_imm, id_crd,
           id_crs1, id_crs2, id_crs3, gpr_rs1_in, rsp_ack,
    input  insn_ack, rsp_valid, rsp_error
  );

  modport slave (
    input  insn_valid, id_class, id_subclass, id_imm, id_crd,
           id_crs1, id_crs2, id_crs3, gpr_rs1_in, rsp_ack,
    output insn_ack, rsp_valid, rsp_error
  );

endinterface

// File: rtl/scarv_cop_mp_wdog.sv
// Loadable saturating cycle counter; flags expiry on the last allowed cycle.
module scarv_cop_mp_wdog #(
  parameter int unsigned WDOG_MAX = 7
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       expired_o
);

  logic [7:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired_o = (count_q == 8'(WDOG_MAX - 1));

endmodule

// File: rtl/scarv_cop_mp_issue.sv
// MP issue stage: accepts one instruction, fetches CPR operands, holds the
// MALU busy until done or watchdog abort, and steers writebacks to CPRs.
module scarv_cop_mp_issue
  import scarv_cop_mp_issue_pkg::*;
#(
  parameter int unsigned CPR_AW   = 4,
  parameter int unsigned WDOG_MAX = 7
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  scarv_cop_mp_issue_if.slave cpu,
  output logic [CPR_AW-1:0] cpr_raddr1,
  output logic [CPR_AW-1:0] cpr_raddr2,
  output logic [CPR_AW-1:0] cpr_raddr3,
  input  logic [31:0]       cpr_rdata1,
  input  logic [31:0]       cpr_rdata2,
  input  logic [31:0]       cpr_rdata3,
  output logic              malu_ivalid,
  input  logic              malu_idone,
  output logic [31:0]       malu_rs1,
  output logic [31:0]       malu_rs2,
  output logic [31:0]       malu_rs3,
  output logic [31:0]       malu_gpr_rs1,
  output logic [31:0]       malu_imm,
  output logic [2:0]        malu_class,
  output logic [3:0]        malu_subclass,
  input  logic [3:0]        malu_ben,
  input  logic [31:0]       malu_wdata,
  output logic [3:0]        cpr_wen,
  output logic [CPR_AW-1:0] cpr_waddr,
  output logic [31:0]       cpr_wdata
);

  issue_state_e      state_q, state_d;
  decode_t           dec_q;
  logic [CPR_AW-1:0] crd_q, crs1_q, crs2_q, crs3_q;
  logic [31:0]       rs1_q, rs2_q, rs3_q;
  logic              wb_idx_q;
  logic              rsp_error_q, rsp_error_d;

  logic accept, capture, retire, abort;
  logic wdog_en, wdog_expired;
  logic wb_active, wb_write;

  scarv_cop_mp_wdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .load_i     (retire),
    .load_val_i (8'd0),
    .en_i       (wdog_en),
    .expired_o  (wdog_expired)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d          = state_q;
    rsp_error_d      = rsp_error_q;
    accept           = 1'b0;
    capture          = 1'b0;
    retire           = 1'b0;
    abort            = 1'b0;
    wdog_en          = 1'b0;
    malu_ivalid      = 1'b0;
    cpu.insn_ack     = 1'b0;
    cpu.rsp_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu.insn_ack = cpu.insn_valid;
        if (cpu.insn_valid) begin
          accept  = 1'b1;
          state_d = ST_OPRD;
        end
      end
      ST_OPRD: begin
        capture = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        malu_ivalid = 1'b1;
        wdog_en     = 1'b1;
        // A genuine completion wins over expiry in the same cycle.
        if (malu_idone) begin
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end else if (wdog_expired) begin
          abort       = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        cpu.rsp_valid = 1'b1;
        if (cpu.rsp_ack) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      dec_q       <= '0;
      crd_q       <= '0;
      crs1_q      <= '0;
      crs2_q      <= '0;
      crs3_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      wb_idx_q    <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_error_q <= rsp_error_d;
      if (accept) begin
        dec_q  <= '{cls:      cpu.id_class,
                    subclass: cpu.id_subclass,
                    imm:      cpu.id_imm,
                    gpr_rs1:  cpu.gpr_rs1_in};
        crd_q  <= cpu.id_crd;
        crs1_q <= cpu.id_crs1;
        crs2_q <= cpu.id_crs2;
        crs3_q <= cpu.id_crs3;
      end
      // Operands are sampled once; later writes to the same CPR do not alias in.
      if (capture) begin
        rs1_q <= cpr_rdata1;
        rs2_q <= cpr_rdata2;
        rs3_q <= cpr_rdata3;
      end
      // Pair index moves to the odd register after the first write and stays there.
      if (retire)        wb_idx_q <= 1'b0;
      else if (wb_write) wb_idx_q <= 1'b1;
    end
  end

  assign wb_active = (state_q == ST_EXEC) && !abort;
  assign wb_write  = wb_active && (malu_ben != 4'd0);

  assign cpr_wen   = wb_active ? malu_ben   : 4'd0;
  assign cpr_wdata = wb_active ? malu_wdata : 32'd0;
  assign cpr_waddr = is_pair_op(dec_q.subclass) ? {crd_q[CPR_AW-1:1], wb_idx_q} : crd_q;

  assign cpr_raddr1 = crs1_q;
  assign cpr_raddr2 = crs2_q;
  assign cpr_raddr3 = crs3_q;

  assign malu_rs1      = rs1_q;
  assign malu_rs2      = rs2_q;
  assign malu_rs3      = rs3_q;
  assign malu_gpr_rs1  = dec_q.gpr_rs1;
  assign malu_imm      = dec_q.imm;
  assign malu_class    = dec_q.cls;
  assign malu_subclass = dec_q.subclass;

  assign cpu.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_scarv_cop_mp_issue.sv
// Self-checking bench for scarv_cop_mp_issue: directed cases plus randomized
// operations checked against a cycle-counting reference model and CPR array.
module tb_scarv_cop_mp_issue;
  import scarv_cop_mp_issue_pkg::*;

  localparam int unsigned CPR_AW   = 4;
  localparam int unsigned WDOG_MAX = 7;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  scarv_cop_mp_issue_if #(.CPR_AW(CPR_AW)) cpu ();

  logic [CPR_AW-1:0] cpr_raddr1, cpr_raddr2, cpr_raddr3, cpr_waddr;
  logic [31:0]       cpr_rdata1, cpr_rdata2, cpr_rdata3, cpr_wdata;
  logic [31:0]       malu_rs1, malu_rs2, malu_rs3, malu_gpr_rs1, malu_imm, malu_wdata;
  logic [2:0]        malu_class;
  logic [3:0]        malu_subclass, malu_ben, cpr_wen;
  logic              malu_ivalid, malu_idone;

  scarv_cop_mp_issue #(.CPR_AW(CPR_AW), .WDOG_MAX(WDOG_MAX)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .cpu           (cpu),
    .cpr_raddr1    (cpr_raddr1),
    .cpr_raddr2    (cpr_raddr2),
    .cpr_raddr3    (cpr_raddr3),
    .cpr_rdata1    (cpr_rdata1),
    .cpr_rdata2    (cpr_rdata2),
    .cpr_rdata3    (cpr_rdata3),
    .malu_ivalid   (malu_ivalid),
    .malu_idone    (malu_idone),
    .malu_rs1      (malu_rs1),
    .malu_rs2      (malu_rs2),
    .malu_rs3      (malu_rs3),
    .malu_gpr_rs1  (malu_gpr_rs1),
    .malu_imm      (malu_imm),
    .malu_class    (malu_class),
    .malu_subclass (malu_subclass),
    .malu_ben      (malu_ben),
    .malu_wdata    (malu_wdata),
    .cpr_wen       (cpr_wen),
    .cpr_waddr     (cpr_waddr),
    .cpr_wdata     (cpr_wdata)
  );

  // CPR file model: read combinationally, written by the scoreboard below.
  logic [31:0] mem [16];
  assign cpr_rdata1 = mem[cpr_raddr1];
  assign cpr_rdata2 = mem[cpr_raddr2];
  assign cpr_rdata3 = mem[cpr_raddr3];

  // Per-EXEC-cycle MALU writeback script.
  logic [31:0] wr_data [16];
  logic [3:0]  wr_ben  [16];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic rand_wr();
    for (int i = 0; i < 16; i++) begin
      wr_ben[i]  = 4'($urandom_range(1, 15));
      wr_data[i] = $urandom;
    end
  endtask

  // One complete operation. done_at: EXEC cycle (1-based) of malu_idone, or
  // anything outside 1..WDOG_MAX for a MALU that never finishes. wmask bit k-1
  // scripts a writeback in EXEC cycle k. rst_at pulses reset in that EXEC cycle.
  task automatic run_op(input logic [3:0] sc, input logic [3:0] crd,
                        input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                        input int done_at, input logic [15:0] wmask,
                        input bit hold, input int rst_at);
    logic [31:0] imm, gpr, e1, e2, e3;
    logic [2:0]  cls;
    logic [3:0]  exp_addr;
    logic        odd;
    bit          pair, err;
    int          last, nwr, nwait;
    imm  = $urandom;
    gpr  = $urandom;
    cls  = 3'($urandom_range(0, 7));
    e1   = mem[c1];
    e2   = mem[c2];
    e3   = mem[c3];
    pair = !(sc == SC_EQU || sc == SC_LTU || sc == SC_GTU);
    last = (done_at >= 1 && done_at <= int'(WDOG_MAX)) ? done_at : int'(WDOG_MAX);
    err  = (last != done_at);
    nwr  = 0;

    tick();
    cpu.rsp_ack     = 1'b0;
    cpu.insn_valid  = 1'b1;
    cpu.id_class    = cls;
    cpu.id_subclass = sc;
    cpu.id_imm      = imm;
    cpu.id_crd      = crd;
    cpu.id_crs1     = c1;
    cpu.id_crs2     = c2;
    cpu.id_crs3     = c3;
    cpu.gpr_rs1_in  = gpr;
    @(negedge g_clk);
    check("ack_idle", 32'(cpu.insn_ack), 32'd1);
    check("ivalid_accept", 32'(malu_ivalid), 32'd0);

    tick();
    if (!hold) cpu.insn_valid = 1'b0;
    cpu.rsp_ack = 1'($urandom_range(0, 1));
    @(negedge g_clk);
    check("ivalid_oprd", 32'(malu_ivalid), 32'd0);
    check("raddr1", 32'(cpr_raddr1), 32'(c1));
    check("raddr2", 32'(cpr_raddr2), 32'(c2));
    check("raddr3", 32'(cpr_raddr3), 32'(c3));
    check("wen_oprd", 32'(cpr_wen), 32'd0);
    if (hold) check("ack_oprd", 32'(cpu.insn_ack), 32'd0);

    for (int k = 1; k <= last; k++) begin
      tick();
      malu_idone  = (k == done_at);
      malu_ben    = wmask[k-1] ? wr_ben[k-1] : 4'd0;
      malu_wdata  = wr_data[k-1];
      cpu.rsp_ack = 1'($urandom_range(0, 1));
      @(negedge g_clk);
      check("ivalid_exec", 32'(malu_ivalid), 32'd1);
      check("rsp_valid_exec", 32'(cpu.rsp_valid), 32'd0);
      check("rs1", malu_rs1, e1);
      check("rs2", malu_rs2, e2);
      check("rs3", malu_rs3, e3);
      check("imm", malu_imm, imm);
      check("gpr", malu_gpr_rs1, gpr);
      check("class", 32'(malu_class), 32'(cls));
      check("subclass", 32'(malu_subclass), 32'(sc));
      if (hold) check("ack_exec", 32'(cpu.insn_ack), 32'd0);
      if (wmask[k-1] && !(err && k == last)) begin
        odd      = (nwr > 0);
        exp_addr = pair ? {crd[3:1], odd} : crd;
        check("wen", 32'(cpr_wen), 32'(wr_ben[k-1]));
        check("waddr", 32'(cpr_waddr), 32'(exp_addr));
        check("wdata", cpr_wdata, wr_data[k-1]);
        if (k != rst_at) begin
          for (int b = 0; b < 4; b++)
            if (wr_ben[k-1][b]) mem[exp_addr][8*b +: 8] = wr_data[k-1][8*b +: 8];
        end
        nwr++;
      end else begin
        check("wen_idle", 32'(cpr_wen), 32'd0);
      end
      if (k == rst_at) begin
        #1 g_resetn = 1'b0;
        #1;
        check("ivalid_rst", 32'(malu_ivalid), 32'd0);
        check("wen_rst", 32'(cpr_wen), 32'd0);
        check("rsp_valid_rst", 32'(cpu.rsp_valid), 32'd0);
        return;
      end
    end

    nwait = $urandom_range(0, 2);
    for (int n = 0; n <= nwait; n++) begin
      tick();
      malu_idone  = 1'b0;
      malu_ben    = 4'd0;
      cpu.rsp_ack = 1'b0;
      @(negedge g_clk);
      check("rsp_valid", 32'(cpu.rsp_valid), 32'd1);
      check("rsp_error", 32'(cpu.rsp_error), 32'(err));
      check("ivalid_resp", 32'(malu_ivalid), 32'd0);
      check("wen_resp", 32'(cpr_wen), 32'd0);
      if (hold) check("ack_resp", 32'(cpu.insn_ack), 32'd0);
    end
    tick();
    cpu.rsp_ack = 1'b1;
    @(negedge g_clk);
    check("rsp_valid_ack", 32'(cpu.rsp_valid), 32'd1);
    if (hold) check("ack_rspack", 32'(cpu.insn_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] sc, crd, c1, c2, c3;
    cpu.insn_valid  = 1'b0;
    cpu.id_class    = '0;
    cpu.id_subclass = '0;
    cpu.id_imm      = '0;
    cpu.id_crd      = '0;
    cpu.id_crs1     = '0;
    cpu.id_crs2     = '0;
    cpu.id_crs3     = '0;
    cpu.gpr_rs1_in  = '0;
    cpu.rsp_ack     = 1'b0;
    malu_idone      = 1'b0;
    malu_ben        = 4'd0;
    malu_wdata      = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset state
    repeat (2) @(negedge g_clk);
    check("rst_ack", 32'(cpu.insn_ack), 32'd0);
    check("rst_rsp_valid", 32'(cpu.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(cpu.rsp_error), 32'd0);
    check("rst_ivalid", 32'(malu_ivalid), 32'd0);
    check("rst_wen", 32'(cpr_wen), 32'd0);
    check("rst_rs1", malu_rs1, 32'd0);
    check("rst_imm", malu_imm, 32'd0);
    check("rst_raddr1", 32'(cpr_raddr1), 32'd0);
    g_resetn = 1'b1;

    // ADD2 pair write: 0xFFFFFFFF + 1 -> 0 into CPR4, carry 1 into CPR5
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'h0000_0001;
    rand_wr();
    wr_data[0] = 32'h0; wr_ben[0] = 4'hF;
    wr_data[1] = 32'h1; wr_ben[1] = 4'hF;
    run_op(SC_ADD2, 4'd5, 4'd2, 4'd3, 4'd0, 2, 16'h0003, 1'b0, 0);

    // EQU: single destination, repeated write stays on crd
    rand_wr();
    wr_data[0] = 32'h1; wr_ben[0] = 4'hF;
    run_op(SC_EQU, 4'd7, 4'd1, 4'd2, 4'd3, 1, 16'h0001, 1'b0, 0);
    rand_wr();
    run_op(SC_LTU, 4'd7, 4'd4, 4'd5, 4'd6, 3, 16'h0005, 1'b0, 0);

    // Hung MALU: abort after WDOG_MAX cycles, writes saturate at odd, last suppressed
    rand_wr();
    run_op(SC_MAC, 4'd10, 4'd1, 4'd2, 4'd3, 0, 16'h007F, 1'b0, 0);

    // idone on the expiry cycle wins
    rand_wr();
    run_op(SC_SUB3, 4'd12, 4'd4, 4'd5, 4'd6, int'(WDOG_MAX), 16'h0040, 1'b0, 0);

    // Write to a source register does not disturb captured operands
    rand_wr();
    run_op(SC_ADD3, 4'd2, 4'd2, 4'd3, 4'd2, 3, 16'h0003, 1'b0, 0);

    // insn_valid held through the whole op, second op accepted right after rsp_ack
    rand_wr();
    run_op(SC_SLL, 4'd6, 4'd7, 4'd8, 4'd9, 2, 16'h0002, 1'b1, 0);
    rand_wr();
    run_op(SC_GTU, 4'd3, 4'd1, 4'd0, 4'd15, 1, 16'h0001, 1'b0, 0);

    // Reset mid-EXEC, then a clean ADD3
    rand_wr();
    run_op(SC_ADD3, 4'd9, 4'd1, 4'd2, 4'd3, 5, 16'h000F, 1'b0, 2);
    cpu.insn_valid = 1'b0;
    cpu.rsp_ack    = 1'b0;
    malu_idone     = 1'b0;
    malu_ben       = 4'd0;
    repeat (2) begin
      @(negedge g_clk);
      check("rst_hold_ivalid", 32'(malu_ivalid), 32'd0);
      check("rst_hold_rsp", 32'(cpu.rsp_valid), 32'd0);
    end
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("post_rst_rsp", 32'(cpu.rsp_valid), 32'd0);
    check("post_rst_ivalid", 32'(malu_ivalid), 32'd0);
    rand_wr();
    run_op(SC_ADD3, 4'd9, 4'd1, 4'd2, 4'd3, 2, 16'h0003, 1'b0, 0);

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      rand_wr();
      sc  = 4'($urandom_range(0, 15));
      crd = 4'($urandom_range(0, 15));
      c1  = 4'($urandom_range(0, 15));
      c2  = 4'($urandom_range(0, 15));
      c3  = 4'($urandom_range(0, 15));
      run_op(sc, crd, c1, c2, c3, $urandom_range(0, WDOG_MAX + 1), 16'($urandom),
             1'($urandom_range(0, 1)), 0);
    end

    tick();
    cpu.insn_valid = 1'b0;
    cpu.rsp_ack    = 1'b0;
    @(negedge g_clk);
    check("final_rsp_valid", 32'(cpu.rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
